// File: rtl/reg_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : reg_rr_arbiter
//  Description : Round-robin arbiter that funnels NUM_REQ requester ports onto
//                a single downstream register bus, one transaction at a time,
//                with an optional downstream wait timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_rr_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  // requester side
  input  logic [NUM_REQ-1:0]              req_valid_i,
  input  logic [NUM_REQ-1:0]              req_write_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0] req_wstrb_i,
  output logic [NUM_REQ-1:0]              rsp_ready_o,
  output logic [DATA_WIDTH-1:0]           rsp_rdata_o,
  output logic                            rsp_error_o,
  // downstream register bus
  output logic                            reg_valid_o,
  output logic                            reg_write_o,
  output logic [ADDR_WIDTH-1:0]           reg_addr_o,
  output logic [DATA_WIDTH-1:0]           reg_wdata_o,
  output logic [DATA_WIDTH/8-1:0]         reg_wstrb_o,
  input  logic                            reg_ready_i,
  input  logic [DATA_WIDTH-1:0]           reg_rdata_i,
  input  logic                            reg_error_i,
  output logic                            timeout_o
);

  localparam int IDX_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int STRB_W      = DATA_WIDTH / 8;
  localparam int CNT_W       = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit TO_EN       = (TIMEOUT_CYCLES > 0);
  localparam int TO_LAST_INT = (TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0;
  localparam logic [CNT_W-1:0] TO_LAST = TO_LAST_INT[CNT_W-1:0];
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  // (base + off) mod NUM_REQ without a divider; off is always < NUM_REQ
  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return s[IDX_W-1:0];
  endfunction

  // --------------------------------------------------------------------------
  // State and latched transaction fields
  // --------------------------------------------------------------------------
  logic [0:0]            state_q,    state_d;
  logic [IDX_W-1:0]      rr_ptr_q,   rr_ptr_d;
  logic [IDX_W-1:0]      grant_q,    grant_d;
  logic [CNT_W-1:0]      wait_cnt_q, wait_cnt_d;
  logic                  write_q,    write_d;
  logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
  logic [DATA_WIDTH-1:0] wdata_q,    wdata_d;
  logic [STRB_W-1:0]     wstrb_q,    wstrb_d;

  // --------------------------------------------------------------------------
  // Unpack the per-requester buses into arrays indexed by requester number
  // --------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] w_addr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] w_wdata [NUM_REQ];
  logic [STRB_W-1:0]     w_wstrb [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_addr[gi]  = req_addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_wdata[gi] = req_wdata_i[gi*DATA_WIDTH +: DATA_WIDTH];
    assign w_wstrb[gi] = req_wstrb_i[gi*STRB_W +: STRB_W];
  end

  // --------------------------------------------------------------------------
  // Arbitration: first valid requester at or above rr_ptr, wrapping around
  // --------------------------------------------------------------------------
  logic             w_any_req;
  logic [IDX_W-1:0] w_arb_idx;

  // Scan requesters starting at the round-robin pointer
  always_comb begin
    logic [IDX_W-1:0] cand;
    w_any_req = 1'b0;
    w_arb_idx = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = wrap_idx(rr_ptr_q, k);
      if (!w_any_req && req_valid_i[cand]) begin
        w_any_req = 1'b1;
        w_arb_idx = cand;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Completion conditions while BUSY. A ready in the last wait cycle wins over
  // the timeout, so the timeout term requires reg_ready_i low.
  // --------------------------------------------------------------------------
  logic w_busy;
  logic w_timeout_hit;
  logic w_done;

  assign w_busy        = (state_q == ST_BUSY);
  assign w_timeout_hit = TO_EN && w_busy && !reg_ready_i && (wait_cnt_q == TO_LAST);
  assign w_done        = w_busy && (reg_ready_i || w_timeout_hit);

  // State register: everything returns to zero on reset, including the pointer
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      wait_cnt_q <= '0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      wait_cnt_q <= wait_cnt_d;
      write_q    <= write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
    end
  end

  // Next-state logic: grant and latch in IDLE, count and complete in BUSY
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    wait_cnt_d = wait_cnt_q;
    write_d    = write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    case (state_q)
      ST_IDLE: begin
        if (w_any_req) begin
          state_d    = ST_BUSY;
          grant_d    = w_arb_idx;
          write_d    = req_write_i[w_arb_idx];
          addr_d     = w_addr[w_arb_idx];
          wdata_d    = w_wdata[w_arb_idx];
          wstrb_d    = w_wstrb[w_arb_idx];
          wait_cnt_d = '0;
        end
      end
      ST_BUSY: begin
        if (w_done) begin
          // no arbitration in a completion cycle: always pass through IDLE
          state_d  = ST_IDLE;
          rr_ptr_d = wrap_idx(grant_q, 1);
        end else if (wait_cnt_q != CNT_MAX) begin
          // saturate so a disabled timeout never sees the counter wrap
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output logic: everything is driven from latched fields while BUSY and is
  // forced to zero in IDLE or while reset is asserted, so an aborted
  // transaction never produces a response.
  always_comb begin
    reg_valid_o = 1'b0;
    reg_write_o = 1'b0;
    reg_addr_o  = '0;
    reg_wdata_o = '0;
    reg_wstrb_o = '0;
    rsp_ready_o = '0;
    rsp_rdata_o = '0;
    rsp_error_o = 1'b0;
    timeout_o   = 1'b0;
    if (w_busy && !rst_i) begin
      reg_valid_o = 1'b1;
      reg_write_o = write_q;
      reg_addr_o  = addr_q;
      reg_wdata_o = wdata_q;
      reg_wstrb_o = wstrb_q;
      rsp_rdata_o = reg_rdata_i;
      rsp_error_o = reg_error_i;
      if (w_timeout_hit) begin
        rsp_ready_o[grant_q] = 1'b1;
        rsp_error_o          = 1'b1;
        rsp_rdata_o          = '0;
        timeout_o            = 1'b1;
      end else if (reg_ready_i) begin
        rsp_ready_o[grant_q] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_rr_arbiter
//  Description : Directed self-checking bench for reg_rr_arbiter with a
//                response scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_rr_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N*SW-1:0] req_wstrb;
  logic [N-1:0]    rsp_ready_o;
  logic [DW-1:0]   rsp_rdata_o;
  logic            rsp_error_o;
  logic            reg_valid_o, reg_write_o;
  logic [AW-1:0]   reg_addr_o;
  logic [DW-1:0]   reg_wdata_o;
  logic [SW-1:0]   reg_wstrb_o;
  logic            reg_ready, reg_error;
  logic [DW-1:0]   reg_rdata;
  logic            timeout_o;

  reg_rr_arbiter #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(4)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_write_i(req_write), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
    .rsp_ready_o(rsp_ready_o), .rsp_rdata_o(rsp_rdata_o), .rsp_error_o(rsp_error_o),
    .reg_valid_o(reg_valid_o), .reg_write_o(reg_write_o), .reg_addr_o(reg_addr_o),
    .reg_wdata_o(reg_wdata_o), .reg_wstrb_o(reg_wstrb_o),
    .reg_ready_i(reg_ready), .reg_rdata_i(reg_rdata), .reg_error_i(reg_error),
    .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    int          idx;
    logic [31:0] rdata;
    logic        err;
    logic        to;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic v, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    req_valid[i]            = v;
    req_write[i]            = w;
    req_addr[i*AW +: AW]    = a;
    req_wdata[i*DW +: DW]   = d;
    req_wstrb[i*SW +: SW]   = s;
  endtask

  task automatic push(input int idx, input logic [31:0] rd, input logic e, input logic t);
    exp_t x;
    x.idx = idx; x.rdata = rd; x.err = e; x.to = t;
    sb.push_back(x);
  endtask

  // Scoreboard monitor: every response pulse must match the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (rsp_ready_o !== '0 || timeout_o !== 1'b0) begin
      chk("rsp_onehot", 64'($onehot(rsp_ready_o)), 64'd1);
      if (sb.size() == 0) begin
        chk("unexpected_rsp", {59'd0, rsp_ready_o, timeout_o}, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("sb_rsp_ready", 64'(rsp_ready_o), 64'd1 << e.idx);
        chk("sb_rsp_rdata", 64'(rsp_rdata_o), 64'(e.rdata));
        chk("sb_rsp_error", 64'(rsp_error_o), 64'(e.err));
        chk("sb_timeout",   64'(timeout_o),   64'(e.to));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    reg_ready = 1'b0; reg_error = 1'b0; reg_rdata = '0;
    step(); step();
    neg();
    chk("rst_reg_valid", 64'(reg_valid_o), 64'd0);
    chk("rst_rsp_ready", 64'(rsp_ready_o), 64'd0);
    step(); rst = 1'b0;
    neg();
    chk("idle_outputs", {27'd0, reg_valid_o, rsp_ready_o, timeout_o, reg_addr_o}, 64'd0);

    // ---- single read from requester 2 ----
    step(); set_req(2, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0); push(2, 32'hDEADBEEF, 1'b0, 1'b0);
    neg();  chk("t1_c0_valid", 64'(reg_valid_o), 64'd0);
    step(); req_valid[2] = 1'b0;
    neg();  chk("t1_c1_valid", 64'(reg_valid_o), 64'd1);
            chk("t1_c1_addr",  64'(reg_addr_o),  64'h40);
            chk("t1_c1_write", 64'(reg_write_o), 64'd0);
    step();
    neg();  chk("t1_c2_valid", 64'(reg_valid_o), 64'd1);
    step(); reg_ready = 1'b1; reg_rdata = 32'hDEADBEEF;
    neg();  chk("t1_c3_addr",  64'(reg_addr_o),  64'h40);
            chk("t1_c3_ready", 64'(rsp_ready_o), 64'h4);
    step(); reg_ready = 1'b0; reg_rdata = '0;
    neg();  chk("t1_c4_valid", 64'(reg_valid_o), 64'd0);

    // ---- fairness: all requesters hold valid, downstream always ready ----
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    step();
    for (int i = 0; i < N; i++)
      set_req(i, 1'b1, 1'b1, 32'h100 + 32'(4*i), 32'h11111111 * 32'(i+1), 4'(1 << i));
    reg_ready = 1'b1; reg_rdata = 32'hC0DE0000;
    for (int t = 0; t < 5; t++) push(t % N, 32'hC0DE0000, 1'b0, 1'b0);
    neg();  chk("t2_c0_valid", 64'(reg_valid_o), 64'd0);
    for (int t = 0; t < 5; t++) begin
      step();
      neg();
      chk("t2_busy_ready", 64'(rsp_ready_o), 64'd1 << (t % N));
      chk("t2_busy_addr",  64'(reg_addr_o),  64'h100 + 64'(4*(t % N)));
      chk("t2_busy_wdata", 64'(reg_wdata_o), 64'h11111111 * 64'((t % N) + 1));
      chk("t2_busy_wstrb", 64'(reg_wstrb_o), 64'd1 << (t % N));
      if (t < 4) begin
        step();
        neg();
        chk("t2_gap_valid", 64'(reg_valid_o), 64'd0);
        chk("t2_gap_ready", 64'(rsp_ready_o), 64'd0);
      end
    end
    step(); req_valid = '0; reg_ready = 1'b0; reg_rdata = '0;

    // ---- timeout on requester 1, requester 3 held off meanwhile ----
    step(); set_req(1, 1'b1, 1'b0, 32'h44, 32'h0, 4'h0); push(1, 32'h0, 1'b1, 1'b1);
    step(); req_valid = '0; reg_rdata = 32'h12345678;
    neg();  chk("t3_c1_valid", 64'(reg_valid_o), 64'd1);
            chk("t3_c1_to",    64'(timeout_o),   64'd0);
    step(); set_req(3, 1'b1, 1'b1, 32'h99, 32'h5, 4'hF);
    neg();  chk("t3_c2_ready", 64'(rsp_ready_o), 64'd0);
    step();
    neg();  chk("t3_c3_to",    64'(timeout_o),   64'd0);
    step(); req_valid[3] = 1'b0;
    neg();  chk("t3_c4_to",    64'(timeout_o),   64'd1);
            chk("t3_c4_err",   64'(rsp_error_o), 64'd1);
            chk("t3_c4_rdata", 64'(rsp_rdata_o), 64'd0);
            chk("t3_c4_valid", 64'(reg_valid_o), 64'd1);
    step(); reg_rdata = '0;
    neg();  chk("t3_c5_valid", 64'(reg_valid_o), 64'd0);
            chk("t3_c5_to",    64'(timeout_o),   64'd0);

    // ---- ready arriving in the timeout cycle wins ----
    step(); set_req(2, 1'b1, 1'b0, 32'h80, 32'h0, 4'h0); push(2, 32'hCAFEF00D, 1'b1, 1'b0);
    step(); req_valid = '0;
    step();
    step();
    step(); reg_ready = 1'b1; reg_error = 1'b1; reg_rdata = 32'hCAFEF00D;
    neg();  chk("t4_c4_to",    64'(timeout_o),   64'd0);
            chk("t4_c4_err",   64'(rsp_error_o), 64'd1);
            chk("t4_c4_ready", 64'(rsp_ready_o), 64'h4);
    step(); reg_ready = 1'b0; reg_error = 1'b0; reg_rdata = '0;

    // ---- latched fields stay stable while the requester changes them ----
    step(); set_req(3, 1'b1, 1'b1, 32'h10, 32'hAAAA5555, 4'hF); push(3, 32'h0, 1'b0, 1'b0);
    step(); set_req(3, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
    neg();  chk("t5_c1_addr",  64'(reg_addr_o),  64'h10);
            chk("t5_c1_write", 64'(reg_write_o), 64'd1);
            chk("t5_c1_wdata", 64'(reg_wdata_o), 64'hAAAA5555);
    step(); req_valid = '0; reg_ready = 1'b1;
    neg();  chk("t5_c2_addr",  64'(reg_addr_o),  64'h10);
            chk("t5_c2_wstrb", 64'(reg_wstrb_o), 64'hF);
            chk("t5_c2_ready", 64'(rsp_ready_o), 64'h8);
    step(); reg_ready = 1'b0;

    // ---- reset in the middle of BUSY ----
    step(); set_req(0, 1'b1, 1'b0, 32'h200, 32'h0, 4'h0); push(0, 32'h0, 1'b0, 1'b0);
    step(); req_valid = '0; reg_ready = 1'b1;
    step(); reg_ready = 1'b0;
    step(); set_req(0, 1'b1, 1'b0, 32'h300, 32'h0, 4'h0);
            set_req(1, 1'b1, 1'b0, 32'h304, 32'h0, 4'h0);
    step();
    neg();  chk("t6_c1_addr",  64'(reg_addr_o),  64'h304);
    step(); rst = 1'b1; reg_ready = 1'b1;
    neg();  chk("t6_c2_ready", 64'(rsp_ready_o), 64'd0);
            chk("t6_c2_to",    64'(timeout_o),   64'd0);
    step(); rst = 1'b0; reg_ready = 1'b0;
    neg();  chk("t6_c3_valid", 64'(reg_valid_o), 64'd0);
    push(0, 32'h5A5A5A5A, 1'b0, 1'b0);
    step(); req_valid = '0;
    neg();  chk("t6_c4_addr",  64'(reg_addr_o),  64'h300);
    step(); reg_ready = 1'b1; reg_rdata = 32'h5A5A5A5A;
    neg();
    step(); reg_ready = 1'b0; reg_rdata = '0;
    step();
    neg();  chk("end_sb_empty", 64'(sb.size()),  64'd0);
            chk("end_valid",    64'(reg_valid_o), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
